// File: rtl/calc_hash_pkg.sv
// Shared types, constants and the CRC-32 step function for the hash-table datapath.
package hash_table;

  localparam int KEY_WIDTH      = 32;
  localparam int VALUE_WIDTH    = 16;
  localparam int BUCKET_WIDTH   = 8;
  localparam int HEAD_PTR_WIDTH = 8;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_SEARCH = 2'd1,
    OP_DELETE = 2'd2,
    OP_NOP    = 2'd3
  } ht_opcode_e;

  typedef struct packed {
    ht_opcode_e             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t               cmd;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_ptr_val;
  } ht_pdata_t;

  localparam int CMD_W   = $bits(ht_command_t);
  localparam int PDATA_W = $bits(ht_pdata_t);

  // Folds the low nbits of data into crc, MSB first, no reflection, no final XOR.
  function automatic logic [31:0] crc32_step(input logic [31:0]          crc,
                                             input logic [KEY_WIDTH-1:0] data,
                                             input int                   nbits);
    logic [31:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[31] ^ data[i];
        c  = {c[30:0], 1'b0};
        if (fb) begin
          c = c ^ CRC32_POLY;
        end else begin
          c = c;
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/calc_hash_stage.sv
// One register slice of the hash pipe: folds this stage's key chunk into the running CRC.
module calc_hash_stage
  import hash_table::*;
#(
  parameter int KEY_WIDTH   = hash_table::KEY_WIDTH,
  parameter int HASH_STAGES = 4,
  parameter int STAGE_IDX   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  output logic             adv_o,
  input  logic             valid_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [31:0]      crc_i,
  output logic             valid_o,
  output logic [CMD_W-1:0] cmd_o,
  output logic [31:0]      crc_o
);

  localparam int CHUNK   = KEY_WIDTH / HASH_STAGES;
  // Key sits directly above the value field in the packed command.
  localparam int KEY_LSB = VALUE_WIDTH;
  localparam int MSB     = KEY_LSB + KEY_WIDTH - 1 - STAGE_IDX * CHUNK;

  logic                           valid_q, valid_d;
  logic [CMD_W-1:0]               cmd_q, cmd_d;
  logic [31:0]                    crc_q, crc_d;
  logic [hash_table::KEY_WIDTH-1:0] chunk_s;

  // Next-state: capture upstream on advance, otherwise hold.
  always_comb begin
    adv_o   = !valid_q || adv_i;
    chunk_s = '0;
    chunk_s[CHUNK-1:0] = cmd_i[MSB -: CHUNK];
    if (adv_o) begin
      valid_d = valid_i;
      cmd_d   = cmd_i;
      crc_d   = crc32_step(crc_i, chunk_s, CHUNK);
    end else begin
      valid_d = valid_q;
      cmd_d   = cmd_q;
      crc_d   = crc_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      crc_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      crc_q   <= crc_d;
    end
  end

  assign valid_o = valid_q;
  assign cmd_o   = cmd_q;
  assign crc_o   = crc_q;

endmodule

// File: rtl/calc_hash.sv
// Pipelined CRC-32 key hash feeding head_table; bubbles collapse via a per-stage advance chain.
module calc_hash
  import hash_table::*;
#(
  parameter int          KEY_WIDTH   = hash_table::KEY_WIDTH,
  parameter int          HASH_STAGES = 4,
  parameter logic [31:0] CRC_INIT    = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CMD_W-1:0]   cmd_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  output logic [PDATA_W-1:0] pdata_out_o,
  output logic               pdata_out_valid_o,
  input  logic               pdata_out_ready_i,
  output logic               busy_o
);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [HASH_STAGES:0] adv_s;
  logic [HASH_STAGES:0] valid_s;
  logic [CMD_W-1:0]     cmd_s [HASH_STAGES+1];
  logic [31:0]          crc_s [HASH_STAGES+1];
  ht_pdata_t            pdata_s;
  logic                 unused_crc_s;

  assign valid_s[0]            = cmd_valid_i;
  assign cmd_s[0]              = cmd_i;
  assign crc_s[0]              = CRC_INIT;
  assign adv_s[HASH_STAGES]    = pdata_out_ready_i;

  for (genvar k = 0; k < HASH_STAGES; k++) begin : g_stage
    calc_hash_stage #(
      .KEY_WIDTH   (KEY_WIDTH),
      .HASH_STAGES (HASH_STAGES),
      .STAGE_IDX   (k)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .adv_i   (adv_s[k+1]),
      .adv_o   (adv_s[k]),
      .valid_i (valid_s[k]),
      .cmd_i   (cmd_s[k]),
      .crc_i   (crc_s[k]),
      .valid_o (valid_s[k+1]),
      .cmd_o   (cmd_s[k+1]),
      .crc_o   (crc_s[k+1])
    );
  end

  // Output record; head_table fills in the head pointer fields.
  always_comb begin
    pdata_s        = '0;
    pdata_s.cmd    = ht_command_t'(cmd_s[HASH_STAGES]);
    pdata_s.bucket = crc_s[HASH_STAGES][BUCKET_WIDTH-1:0];
  end

  assign unused_crc_s      = ^crc_s[HASH_STAGES][31:BUCKET_WIDTH];
  assign pdata_out_o       = pdata_s;
  assign pdata_out_valid_o = valid_s[HASH_STAGES];
  assign cmd_ready_o       = adv_s[0];
  assign busy_o            = |valid_s[HASH_STAGES:1];

endmodule

// File: tb/tb_calc_hash.sv
// Randomized self-checking bench for calc_hash against a polynomial-division CRC model.
module tb_calc_hash;
  import hash_table::*;

  logic               clk;
  logic               rst_i;
  logic [CMD_W-1:0]   cmd_i;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [PDATA_W-1:0] pdata_out_o;
  logic               pdata_out_valid_o;
  logic               pdata_out_ready_i;
  logic               busy_o;

  calc_hash dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .cmd_i             (cmd_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .pdata_out_o       (pdata_out_o),
    .pdata_out_valid_o (pdata_out_valid_o),
    .pdata_out_ready_i (pdata_out_ready_i),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int out_count = 0;

  logic [127:0] exp_q [$];
  logic [127:0] log_q [$];
  int           out_cyc_q [$];
  logic         hold_prev = 1'b0;
  logic [127:0] prev_pdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // CRC-32 (init 0, no reflection, no final XOR) = remainder of key*x^32 mod P(x).
  function automatic logic [31:0] ref_crc(input logic [KEY_WIDTH-1:0] key);
    logic [KEY_WIDTH+31:0] v;
    logic [KEY_WIDTH+31:0] poly;
    v    = {key, 32'h0};
    poly = '0;
    poly[32:0] = 33'h1_04C1_1DB7;
    for (int i = KEY_WIDTH + 31; i >= 32; i--)
      if (v[i]) v = v ^ (poly << (i - 32));
    return v[31:0];
  endfunction

  function automatic logic [127:0] exp_pdata(input ht_command_t c);
    ht_pdata_t   p;
    logic [31:0] crc;
    crc      = ref_crc(c.key);
    p        = '0;
    p.cmd    = c;
    p.bucket = crc[BUCKET_WIDTH-1:0];
    return 128'(p);
  endfunction

  function automatic ht_command_t rand_cmd();
    ht_command_t c;
    c.opcode = ht_opcode_e'($urandom_range(0, 3));
    c.key    = $urandom;
    c.value  = VALUE_WIDTH'($urandom);
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard/monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 128'(pdata_out_valid_o), 128'd1);
        check("stall_data", 128'(pdata_out_o), prev_pdata);
      end
      if (cmd_valid_i && cmd_ready_o) exp_q.push_back(exp_pdata(ht_command_t'(cmd_i)));
      if (pdata_out_valid_o && pdata_out_ready_i) begin
        out_count++;
        out_cyc_q.push_back(cyc);
        log_q.push_back(128'(pdata_out_o));
        check("out_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check("out_entry", 128'(pdata_out_o), exp_q.pop_front());
      end
      hold_prev  = pdata_out_valid_o && !pdata_out_ready_i;
      prev_pdata = 128'(pdata_out_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ht_command_t c;
    ht_pdata_t   p;
    logic [127:0] snap;
    int base, base_cnt, sent, guard;
    logic acc;

    rst_i = 1'b1; cmd_i = '0; cmd_valid_i = 1'b0; pdata_out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    check("rst_valid", 128'(pdata_out_valid_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_ready", 128'(cmd_ready_o), 128'd1);
    check("rst_pdata", 128'(pdata_out_o), 128'd0);

    // Key 0: four-stage latency, bucket 0.
    pdata_out_ready_i = 1'b1;
    c = rand_cmd(); c.key = '0;
    cmd_i = c; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step(); step();
    check("lat_early", 128'(pdata_out_valid_o), 128'd0);
    step();
    check("lat_valid", 128'(pdata_out_valid_o), 128'd1);
    p = ht_pdata_t'(pdata_out_o);
    check("key0_bucket", 128'(p.bucket), 128'd0);
    step();

    // 16 back-to-back keys at full throughput.
    base = out_cyc_q.size();
    for (int i = 0; i < 16; i++) begin
      cmd_i = rand_cmd(); cmd_valid_i = 1'b1;
      step();
    end
    cmd_valid_i = 1'b0;
    repeat (6) step();
    check("stream_count", 128'(out_cyc_q.size() - base), 128'd16);
    if (out_cyc_q.size() - base == 16)
      check("stream_span", 128'(out_cyc_q[base+15] - out_cyc_q[base]), 128'd15);

    // Fill with downstream stalled, then drain.
    pdata_out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 128'(cmd_ready_o), 128'd1);
      cmd_i = rand_cmd(); cmd_valid_i = 1'b1;
      step();
    end
    cmd_valid_i = 1'b0;
    check("full_ready", 128'(cmd_ready_o), 128'd0);
    snap = 128'(pdata_out_o);
    repeat (3) step();
    check("full_stable", 128'(pdata_out_o), snap);
    pdata_out_ready_i = 1'b1;
    #1;
    check("full_pass_ready", 128'(cmd_ready_o), 128'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 128'(pdata_out_valid_o), 128'd1);
      step();
    end
    check("drain_empty", 128'(busy_o), 128'd0);

    // Same key, different values.
    base = log_q.size();
    c = rand_cmd();
    cmd_i = c; cmd_valid_i = 1'b1;
    step();
    c.value = c.value ^ 16'h5A5A;
    cmd_i = c;
    step();
    cmd_valid_i = 1'b0;
    repeat (6) step();
    check("dup_count", 128'(log_q.size() - base), 128'd2);
    if (log_q.size() - base == 2)
      check("dup_bucket", 128'(log_q[base][8+1 +: BUCKET_WIDTH]),
            128'(log_q[base+1][8+1 +: BUCKET_WIDTH]));

    // Random valid/ready traffic.
    base_cnt = out_count; sent = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!cmd_valid_i && ($urandom % 2 == 0)) begin
        cmd_i = rand_cmd(); cmd_valid_i = 1'b1;
      end
      pdata_out_ready_i = ($urandom % 2 == 0);
      #1;
      acc = cmd_valid_i && cmd_ready_o;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        cmd_valid_i = 1'b0;
      end
      guard++;
    end
    cmd_valid_i = 1'b0;
    pdata_out_ready_i = 1'b1;
    for (int i = 0; i < 50 && busy_o; i++) step();
    check("rand_sent", 128'(sent), 128'd1000);
    check("rand_out", 128'(out_count - base_cnt), 128'd1000);
    check("rand_left", 128'(exp_q.size()), 128'd0);
    check("rand_busy", 128'(busy_o), 128'd0);

    // Reset with three entries in flight.
    pdata_out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_i = rand_cmd(); cmd_valid_i = 1'b1;
      step();
    end
    cmd_valid_i = 1'b0;
    check("pre_rst_busy", 128'(busy_o), 128'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_valid", 128'(pdata_out_valid_o), 128'd0);
    check("rst_mid_busy", 128'(busy_o), 128'd0);
    step();
    rst_i = 1'b0;
    pdata_out_ready_i = 1'b1;
    base_cnt = out_count;
    repeat (8) step();
    check("post_rst_out", 128'(out_count - base_cnt), 128'd0);
    check("post_rst_busy", 128'(busy_o), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_hash.md
# calc_hash

Pipelined hash stage at the front of the hash-table datapath: accepts a command (`ht_command_t`), computes a CRC-32 over the key in `HASH_STAGES` chunked steps, and emits an `ht_pdata_t` whose `bucket` field addresses the head table. It sits directly upstream of `head_table`, and its output handshake connects one-to-one to `head_table`'s `pdata_in_*` ports. `busy_o` lets the top-level clear sequencer wait for the pipe to drain before starting a RAM clear.

## Interface
- `KEY_WIDTH`, default `hash_table::KEY_WIDTH`: key bits hashed; must be divisible by `HASH_STAGES`.
- `HASH_STAGES`, default 4: pipeline depth; each stage folds `KEY_WIDTH/HASH_STAGES` key bits.
- `CRC_INIT`, default 32'h0: CRC seed.
- `clk_i`, input, 1: clock. The block has one clock; reset is asynchronous and active-high.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `cmd_i`, input, `$bits(ht_command_t)`: command (`opcode`, `key`, `value`).
- `cmd_valid_i`, input, 1: command valid.
- `cmd_ready_o`, output, 1: stage 0 can accept.
- `pdata_out_o`, output, `$bits(ht_pdata_t)`: command plus `bucket`.
- `pdata_out_valid_o`, output, 1: output valid.
- `pdata_out_ready_i`, input, 1: downstream (`head_table`) accepts.
- `busy_o`, output, 1: at least one stage holds a valid entry.

## Operation
- Stage k (0..`HASH_STAGES`-1) holds the following registers: `valid[k]`, `cmd[k]`, `crc[k]`.
- Stage 0 loads `crc = step(CRC_INIT, chunk0)`.
- Stage k loads `crc = step(crc[k-1], chunk_k)`.
- Chunk 0 is `key[KEY_WIDTH-1 -: C]` (MSB first), with `C = KEY_WIDTH/HASH_STAGES`.
- `step` is a bitwise CRC-32 update:
  - polynomial 0x04C11DB7;
  - MSB-first, no reflection;
  - no final XOR.
- Output fields:
  - `pdata_out_o.cmd` = `cmd[last]`.
  - `pdata_out_o.bucket` = `crc[last][BUCKET_WIDTH-1:0]`.
  - `head_ptr` = 0 and `head_ptr_val` = 0. `head_table` fills these in.
  - All other `ht_pdata_t` fields are 0.
- Per-stage advance:
  - `adv[last] = !valid[last] || pdata_out_ready_i`.
  - `adv[k] = !valid[k] || adv[k+1]`.
  - `cmd_ready_o = adv[0]`.
- Bubbles collapse: a stalled tail does not block earlier stages that still have empty slots downstream.
- On `adv[k]`, stage k captures the stage k-1 contents (or the input for k=0), and `valid[k]` takes the upstream valid.
- When a stage does not advance, it holds its data and valid unchanged.
- `pdata_out_valid_o = valid[last]`.
- `busy_o = |valid`.
- Entries leave in order. No entry is dropped or duplicated under any ready pattern.

## Timing
- Reset values:
  - all `valid` = 0 and `pdata_out_valid_o` = 0;
  - `busy_o` = 0;
  - `cmd_ready_o` = 1 (pipe empty);
  - data registers = 0.
- Latency: an entry accepted at edge N appears on `pdata_out_o` after edge N+`HASH_STAGES-1`, i.e. `HASH_STAGES` register stages. With ready held high, throughput is 1 per cycle.
- Handshake: a transfer happens when valid and ready are both high at a rising edge. Rules for this block:
  - It never drops `pdata_out_valid_o` without a transfer.
  - It never changes `pdata_out_o` while valid is high and ready is low.
- `cmd_ready_o` is combinational from `pdata_out_ready_i` through the `adv` chain.
- `cmd_ready_o` does not depend on `cmd_valid_i`.
- Full pipe with `pdata_out_ready_i` = 0: `cmd_ready_o` = 0.
- Full pipe with `pdata_out_ready_i` = 1: simultaneous accept and emit in the same cycle.
- Reset asserted mid-flight: all valids clear immediately (asynchronous). In-flight entries are discarded, and the upstream must re-issue them.

## Structure
- `hash_table` package holds:
  - `KEY_WIDTH`, `BUCKET_WIDTH`;
  - `ht_command_t`, `ht_pdata_t`;
  - `CRC32_POLY`;
  - function `crc32_step(crc, data)`, parameterised by chunk width through a loop over bits.
- One sub-module, `calc_hash_stage`:
  - one register slice holding valid, cmd and crc;
  - `adv` in, `adv` out.
- `calc_hash` instantiates `HASH_STAGES` copies with a generate loop and builds the `adv` chain.

## Test plan
- Key = 0, `CRC_INIT` = 0, ready held 1 → `bucket` = 0 after exactly 4 cycles.
- Stream of 16 random keys back to back, ready = 1 → 16 outputs on consecutive cycles, in order, with `bucket` equal to the golden-model CRC-32 (poly 0x04C11DB7, init 0) truncated to `BUCKET_WIDTH`.
- Fill with 4 entries while `pdata_out_ready_i` = 0:
  - `cmd_ready_o` falls to 0 after the 4th accept;
  - `pdata_out_o` is stable;
  - after ready goes to 1, all 4 drain on 4 consecutive cycles.
- Random valid/ready, 50% each, 1000 commands → scoreboard shows no loss, duplication or reordering; `busy_o` = 0 once drained.
- Identical key sent twice with different `value` → both outputs carry the same `bucket`; `cmd.value` is preserved per entry.
- Assert `rst_i` with 3 entries in flight → `pdata_out_valid_o` and `busy_o` go to 0 immediately, and no stale output appears after reset release.
